// File: rtl/lane_to_fifo_bridge.sv
// Lane RX byte stream to FIFO bridge: restores MSB-first order and tags the last byte of each burst.
// Optional burst length counter enabled by defining LANE_RX_BURST_LEN_EN.
module lane_to_fifo_bridge (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_active,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic        rx_mode_lp,
    output logic [8:0]  fifo_data,
    output logic        fifo_write,
    input  logic        fifo_full,
    output logic        burst_lp,
    output logic        overflow,
    input  logic        ovf_clr,
    output logic        burst_done,
    output logic [15:0] burst_len
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EMPTY = 2'd1,
        ST_HOLD  = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic        act_d_r;
    logic [7:0]  buf_r;
    logic        start_s;
    logic        strobe_s;
    logic        begin_s;
    logic        load_s;
    logic        drop_s;
    logic        last_s;

    function automatic logic [7:0] bit_rev(input logic [7:0] d);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[7-i] = d[i];
        end
        return r;
    endfunction

    assign start_s   = rx_active & ~act_d_r;
    assign strobe_s  = rx_active & rx_valid;
    assign fifo_data = {last_s, buf_r};

    // Next-state, write strobe and buffer control
    always_comb begin
        state_s    = state_r;
        fifo_write = 1'b0;
        last_s     = 1'b0;
        begin_s    = 1'b0;
        load_s     = 1'b0;
        drop_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    begin_s = 1'b1;
                    load_s  = strobe_s;
                    state_s = strobe_s ? ST_HOLD : ST_EMPTY;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_EMPTY: begin
                if (strobe_s) begin
                    load_s  = 1'b1;
                    state_s = ST_HOLD;
                end else if (!rx_active) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_EMPTY;
                end
            end
            ST_HOLD: begin
                if (strobe_s) begin
                    load_s     = 1'b1;
                    drop_s     = fifo_full;
                    fifo_write = ~fifo_full;
                end else if (!rx_active) begin
                    if (fifo_full) begin
                        state_s = ST_FLUSH;
                    end else begin
                        fifo_write = 1'b1;
                        last_s     = 1'b1;
                        state_s    = ST_IDLE;
                    end
                end else begin
                    state_s = ST_HOLD;
                end
            end
            ST_FLUSH: begin
                drop_s = strobe_s;
                if (!fifo_full) begin
                    fifo_write = 1'b1;
                    last_s     = 1'b1;
                    state_s    = ST_IDLE;
                end else begin
                    state_s = ST_FLUSH;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, edge detect, holding buffer, burst mode and sticky overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            act_d_r  <= 1'b1;   // a burst already in progress at reset release is not entered
            buf_r    <= 8'h00;
            burst_lp <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state_r <= state_s;
            act_d_r <= rx_active;
            if (load_s) begin
                buf_r <= bit_rev(rx_data);
            end
            if (begin_s) begin
                burst_lp <= rx_mode_lp;
            end
            if (drop_s) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

`ifdef LANE_RX_BURST_LEN_EN
    logic [15:0] cnt_r;
    logic        end_s;

    assign end_s = ~rx_active & ((state_r == ST_EMPTY) | (state_r == ST_HOLD));

    // Saturating byte counter and registered end-of-burst report
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r      <= 16'h0000;
            burst_done <= 1'b0;
            burst_len  <= 16'h0000;
        end else begin
            if (begin_s) begin
                cnt_r <= load_s ? 16'h0001 : 16'h0000;
            end else if (load_s && (cnt_r != 16'hFFFF)) begin
                cnt_r <= cnt_r + 16'h0001;
            end
            burst_done <= end_s;
            if (end_s) begin
                burst_len <= cnt_r;
            end
        end
    end
`else
    assign burst_done = 1'b0;
    assign burst_len  = 16'h0000;
`endif

endmodule

// File: tb/tb_lane_to_fifo_bridge.sv
// Scoreboard bench for lane_to_fifo_bridge: directed scenarios plus randomized bursts against a burst-level model.
module tb_lane_to_fifo_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx_active;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_mode_lp;
    logic [8:0]  fifo_data;
    logic        fifo_write;
    logic        fifo_full;
    logic        burst_lp;
    logic        overflow;
    logic        ovf_clr;
    logic        burst_done;
    logic [15:0] burst_len;

    lane_to_fifo_bridge dut (
        .clk(clk), .rst_n(rst_n), .rx_active(rx_active), .rx_valid(rx_valid),
        .rx_data(rx_data), .rx_mode_lp(rx_mode_lp), .fifo_data(fifo_data),
        .fifo_write(fifo_write), .fifo_full(fifo_full), .burst_lp(burst_lp),
        .overflow(overflow), .ovf_clr(ovf_clr), .burst_done(burst_done),
        .burst_len(burst_len)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic [8:0] exp_q[$];
    logic [8:0] wr_log[$];

    // model: current (visible) values and values for the next cycle
    bit         m_prev, m_inb, m_has, m_fl, m_ovf, m_lp, m_done;
    logic [7:0] m_held;
    int         m_cnt, m_len;
    bit         n_prev, n_inb, n_has, n_fl, n_ovf, n_lp, n_done;
    logic [7:0] n_held;
    int         n_cnt, n_len;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] d);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[7-i] = d[i];
        return r;
    endfunction

    task automatic model_reset();
        m_prev = 1'b1; m_inb = 1'b0; m_has = 1'b0; m_fl = 1'b0; m_ovf = 1'b0;
        m_lp = 1'b0; m_done = 1'b0; m_held = 8'h00; m_cnt = 0; m_len = 0;
        n_prev = 1'b1; n_inb = 1'b0; n_has = 1'b0; n_fl = 1'b0; n_ovf = 1'b0;
        n_lp = 1'b0; n_done = 1'b0; n_held = 8'h00; n_cnt = 0; n_len = 0;
        exp_q.delete();
    endtask

    // one clock: commit model, drive inputs, predict this cycle's write and next state
    task automatic cyc(input bit a, input bit v, input logic [7:0] d, input bit lp,
                       input bit full, input bit clr);
        bit drop;
        bit strobe;
        @(posedge clk);
        #1;
        m_prev = n_prev; m_inb = n_inb; m_has = n_has; m_fl = n_fl; m_ovf = n_ovf;
        m_lp = n_lp; m_done = n_done; m_held = n_held; m_cnt = n_cnt; m_len = n_len;
        rx_active = a; rx_valid = v; rx_data = d; rx_mode_lp = lp;
        fifo_full = full; ovf_clr = clr;
        drop = 1'b0;
        strobe = a & v;
        n_done = 1'b0;
        n_prev = a;
        if (m_fl) begin
            drop = strobe;
            if (!full) begin
                exp_q.push_back({1'b1, m_held});
                n_fl = 1'b0;
                n_has = 1'b0;
            end
        end else if (m_inb) begin
            if (strobe) begin
                if (n_cnt < 65535) n_cnt = n_cnt + 1;
                if (m_has) begin
                    if (full) drop = 1'b1;
                    else exp_q.push_back({1'b0, m_held});
                end
                n_held = rev8(d);
                n_has = 1'b1;
            end else if (!a) begin
                n_done = 1'b1;
                n_len = m_cnt;
                n_inb = 1'b0;
                if (m_has) begin
                    if (full) n_fl = 1'b1;
                    else begin
                        exp_q.push_back({1'b1, m_held});
                        n_has = 1'b0;
                    end
                end
            end
        end else if (a && !m_prev) begin
            n_inb = 1'b1;
            n_lp = lp;
            n_cnt = 0;
            if (strobe) begin
                n_cnt = 1;
                n_held = rev8(d);
                n_has = 1'b1;
            end
        end
        n_ovf = drop ? 1'b1 : (clr ? 1'b0 : m_ovf);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_log(input string name, input int n, input logic [8:0] e0,
                             input logic [8:0] e1, input logic [8:0] e2);
        logic [8:0] e[3];
        e[0] = e0; e[1] = e1; e[2] = e2;
        check({name, "_count"}, wr_log.size(), n);
        for (int i = 0; i < n && i < wr_log.size(); i++) check({name, "_data"}, wr_log[i], e[i]);
        wr_log.delete();
    endtask

    // monitor: pop expected writes and compare status outputs each cycle
    always @(negedge clk) begin
        if (fifo_write === 1'b1) begin
            wr_log.push_back(fifo_data);
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'd1, 32'd0);
            end else begin
                check("fifo_data", {23'd0, fifo_data}, {23'd0, exp_q.pop_front()});
            end
        end
        check("overflow", {31'd0, overflow}, {31'd0, m_ovf});
        check("burst_lp", {31'd0, burst_lp}, {31'd0, m_lp});
`ifdef LANE_RX_BURST_LEN_EN
        check("burst_done", {31'd0, burst_done}, {31'd0, m_done});
        check("burst_len", {16'd0, burst_len}, m_len[31:0]);
`endif
    end

    initial begin
        model_reset();
        rst_n = 1'b0; rx_active = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        rx_mode_lp = 1'b0; fifo_full = 1'b0; ovf_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_write", {31'd0, fifo_write}, 32'd0);
        check("reset_data", {23'd0, fifo_data}, 32'd0);
        rst_n = 1'b1;
        idle(2);

        // three-byte burst, FIFO free
        cyc(1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 8'h80, 1'b0, 1'b0, 1'b0);
        idle(3);
        check_log("burst3", 3, 9'h0A5, 9'h080, 9'h101);
        check("burst3_lp", {31'd0, burst_lp}, 32'd1);

        // single byte strobed on the rising edge of rx_active
        cyc(1'b1, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0);
        idle(3);
        check_log("single", 1, 9'h1C0, 9'h000, 9'h000);

        // empty burst
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        idle(3);
        check_log("empty", 0, 9'h000, 9'h000, 9'h000);

        // FIFO full on the second strobe drops the first byte
        cyc(1'b1, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 8'h22, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
        idle(2);
        #4;
        check("ovf_set", {31'd0, overflow}, 32'd1);
        check_log("drop", 2, 9'h044, 9'h1CC, 9'h000);
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        idle(1);
        #4;
        check("ovf_clr", {31'd0, overflow}, 32'd0);

        // last byte held in FLUSH while the FIFO stays full
        cyc(1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        #4;
        check("flush_wait", wr_log.size(), 0);
        idle(2);
        check_log("flush", 1, 9'h1FF, 9'h000, 9'h000);

        // reset while holding a byte mid-burst
        cyc(1'b1, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_write", {31'd0, fifo_write}, 32'd0);
        check("rst_data", {23'd0, fifo_data}, 32'd0);
        check("rst_lp", {31'd0, burst_lp}, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);
        check("rst_done", {31'd0, burst_done}, 32'd0);
        check("rst_len", {16'd0, burst_len}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        wr_log.delete();
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
        check_log("post_rst_active", 0, 9'h000, 9'h000, 9'h000);
        idle(2);
        check_log("post_rst_fall", 0, 9'h000, 9'h000, 9'h000);
        cyc(1'b1, 1'b1, 8'h0F, 1'b0, 1'b0, 1'b0);
        idle(2);
        check_log("post_rst_new", 1, 9'h1F0, 9'h000, 9'h000);

        // randomized bursts
        for (int b = 0; b < 300; b++) begin
            bit lp;
            int len;
            lp = 1'($urandom_range(1, 0));
            len = $urandom_range(7, 0);
            for (int i = 0; i < len; i++) begin
                cyc(1'b1, ($urandom_range(9, 0) < 6), 8'($urandom), lp,
                    ($urandom_range(3, 0) == 0), ($urandom_range(9, 0) == 0));
            end
            for (int i = 0; i < int'($urandom_range(4, 1)); i++) begin
                cyc(1'b0, 1'($urandom_range(1, 0)), 8'($urandom), lp,
                    ($urandom_range(2, 0) == 0), ($urandom_range(9, 0) == 0));
            end
            if ($urandom_range(19, 0) == 0) begin
                // burst starting while the FIFO blocks the final byte
                cyc(1'b1, 1'b1, 8'($urandom), lp, 1'b0, 1'b0);
                cyc(1'b0, 1'b0, 8'h00, lp, 1'b1, 1'b0);
                cyc(1'b1, 1'b1, 8'($urandom), lp, 1'b1, 1'b0);
                cyc(1'b1, 1'b1, 8'($urandom), lp, 1'b0, 1'b0);
                cyc(1'b0, 1'b0, 8'h00, lp, 1'b0, 1'b0);
            end
        end
        idle(4);
        wr_log.delete();
        check("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
